// File: rtl/reconstruct_l5_if.sv
// Sample bus of the level-5 synthesis stage: input pair in, reconstructed fp32 stream out.
interface reconstruct_l5_if;
    localparam int unsigned DW = 32;

    logic          din_valid;
    logic [DW-1:0] a5_0;
    logic [DW-1:0] d5_0;
    logic          dout_valid;
    logic          dout_phase;
    logic [DW-1:0] a4_r;
    logic          err_overrun;

    modport master (
        output din_valid, a5_0, d5_0,
        input  dout_valid, dout_phase, a4_r, err_overrun
    );

    modport slave (
        input  din_valid, a5_0, d5_0,
        output dout_valid, dout_phase, a4_r, err_overrun
    );
endinterface

// File: rtl/reconstruct_l5.sv
// Level-5 sym4 synthesis stage: 2x upsample, 8-tap fp32 filter pair, even/odd output pair per input.
module reconstruct_l5 #(
    parameter logic [31:0] REC_L0 = 32'h3d03fc5f,
    parameter logic [31:0] REC_L1 = 32'hbc4e80df,
    parameter logic [31:0] REC_L2 = 32'hbdcb339e,
    parameter logic [31:0] REC_L3 = 32'h3e9880d1,
    parameter logic [31:0] REC_L4 = 32'h3f4dc1d3,
    parameter logic [31:0] REC_L5 = 32'h3efec7e0,
    parameter logic [31:0] REC_L6 = 32'hbcf2c635,
    parameter logic [31:0] REC_L7 = 32'hbd9b2b0e,
    parameter logic [31:0] REC_H0 = 32'hbd03fc5f,
    parameter logic [31:0] REC_H1 = 32'hbc4e80df,
    parameter logic [31:0] REC_H2 = 32'h3dcb339e,
    parameter logic [31:0] REC_H3 = 32'h3e9880d1,
    parameter logic [31:0] REC_H4 = 32'hbf4dc1d3,
    parameter logic [31:0] REC_H5 = 32'h3efec7e0,
    parameter logic [31:0] REC_H6 = 32'h3cf2c635,
    parameter logic [31:0] REC_H7 = 32'hbd9b2b0e,
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned ADD_LAT  = 3
) (
    input logic              clk_312_5,
    input logic              rst,
    reconstruct_l5_if.slave  bus
);
    localparam int unsigned NT   = 8;
    localparam int unsigned VLAT = MULT_LAT + 3 * ADD_LAT + 3;
    localparam logic [31:0] TL [NT] = '{REC_L0, REC_L1, REC_L2, REC_L3, REC_L4, REC_L5, REC_L6, REC_L7};
    localparam logic [31:0] TH [NT] = '{REC_H0, REC_H1, REC_H2, REC_H3, REC_H4, REC_H5, REC_H6, REC_H7};

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    // fp32 multiply, round-to-nearest-even; subnormals treated as zero
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [9:0]  e;
        logic [23:0]        m;
        logic               g, st;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
        end
        m = m + 24'(g & (st | m[0]));
        if (m[23]) e = e + 10'sd1;
        if (e <= 10'sd0)   return {s, 31'd0};
        if (e >= 10'sd255) return {s, 8'hff, 23'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // fp32 add, round-to-nearest-even; 26 spare low bits keep alignment losses as a sticky bit
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         d;
        logic [49:0]        xm, ym, ys;
        logic [50:0]        sum;
        logic signed [9:0]  e;
        logic [23:0]        m;
        logic               g, st;
        int                 pos;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d  = x[30:23] - y[30:23];
        xm = {1'b1, x[22:0], 26'd0};
        ym = {1'b1, y[22:0], 26'd0};
        if (d >= 8'd50) ys = 50'd1;
        else begin
            ys = ym >> d;
            if ((ym & ((50'd1 << d) - 50'd1)) != 50'd0) ys[0] = 1'b1;
        end
        sum = (x[31] ^ y[31]) ? ({1'b0, xm} - {1'b0, ys}) : ({1'b0, xm} + {1'b0, ys});
        if (sum == 51'd0) return 32'd0;
        e = {2'b00, x[30:23]};
        if (sum[50]) begin
            sum = {1'b0, sum[50:2], sum[1] | sum[0]};
            e   = e + 10'sd1;
        end else begin
            pos = 0;
            for (int i = 0; i < 50; i++) if (sum[i]) pos = i;
            sum = sum << (49 - pos);
            e   = e - 10'(49 - pos);
        end
        m  = {1'b0, sum[48:26]};
        g  = sum[25];
        st = |sum[24:0];
        m  = m + 24'(g & (st | m[0]));
        if (m[23]) e = e + 10'sd1;
        if (e <= 10'sd0)   return 32'd0;
        if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
        return {x[31], e[7:0], m[22:0]};
    endfunction

    state_t           state, state_next;
    logic [31:0]      ha [4];
    logic [31:0]      hd [4];
    logic [2:0]       fill;
    logic             acc_q;
    logic             accept_c, issue_c;
    logic [31:0]      opa [NT];
    logic [31:0]      opb [NT];
    logic [31:0]      mpipe [MULT_LAT][NT];
    logic [31:0]      prod_q [NT];
    logic [31:0]      a1 [ADD_LAT][4];
    logic [31:0]      s1_q [4];
    logic [31:0]      a2 [ADD_LAT][2];
    logic [31:0]      s2_q [2];
    logic [31:0]      a3 [ADD_LAT];
    logic [VLAT-1:0]  vsh, psh;

    // back-to-back valids are dropped: the multipliers are busy for two cycles per issue
    assign accept_c = bus.din_valid && !acc_q;
    assign issue_c  = accept_c && (fill >= 3'd3);

    always_ff @(posedge clk_312_5) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (issue_c)            state_next = EVEN;
        else if (state == EVEN) state_next = ODD;
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                ha[k] <= '0;
                hd[k] <= '0;
            end
            fill            <= '0;
            acc_q           <= 1'b0;
            bus.err_overrun <= 1'b0;
        end else begin
            acc_q <= accept_c;
            if (accept_c) begin
                ha[0] <= bus.a5_0;
                hd[0] <= bus.d5_0;
                for (int k = 1; k < 4; k++) begin
                    ha[k] <= ha[k-1];
                    hd[k] <= hd[k-1];
                end
                if (fill != 3'd4) fill <= fill + 3'd1;
            end
            if (bus.din_valid && acc_q) bus.err_overrun <= 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            opa[j]     = ha[j];
            opa[j + 4] = hd[j];
            opb[j]     = (state == ODD) ? TL[2*j + 1] : TL[2*j];
            opb[j + 4] = (state == ODD) ? TH[2*j + 1] : TH[2*j];
        end
    end

    // products 0..3 approximation, 4..7 detail; tree order (0+1),(2+3),(4+5),(6+7) is fixed
    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            for (int unsigned s = 0; s < MULT_LAT; s++)
                for (int k = 0; k < 8; k++) mpipe[s][k] <= '0;
            for (int unsigned s = 0; s < ADD_LAT; s++) begin
                for (int k = 0; k < 4; k++) a1[s][k] <= '0;
                for (int k = 0; k < 2; k++) a2[s][k] <= '0;
                a3[s] <= '0;
            end
            for (int k = 0; k < 8; k++) prod_q[k] <= '0;
            for (int k = 0; k < 4; k++) s1_q[k] <= '0;
            for (int k = 0; k < 2; k++) s2_q[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) mpipe[0][k] <= fmul(opa[k], opb[k]);
            for (int k = 0; k < 4; k++) a1[0][k] <= fadd(prod_q[2*k], prod_q[2*k + 1]);
            for (int k = 0; k < 2; k++) a2[0][k] <= fadd(s1_q[2*k], s1_q[2*k + 1]);
            a3[0] <= fadd(s2_q[0], s2_q[1]);
            for (int unsigned s = 1; s < MULT_LAT; s++)
                for (int k = 0; k < 8; k++) mpipe[s][k] <= mpipe[s-1][k];
            for (int unsigned s = 1; s < ADD_LAT; s++) begin
                for (int k = 0; k < 4; k++) a1[s][k] <= a1[s-1][k];
                for (int k = 0; k < 2; k++) a2[s][k] <= a2[s-1][k];
                a3[s] <= a3[s-1];
            end
            for (int k = 0; k < 8; k++) prod_q[k] <= mpipe[MULT_LAT-1][k];
            for (int k = 0; k < 4; k++) s1_q[k] <= a1[ADD_LAT-1][k];
            for (int k = 0; k < 2; k++) s2_q[k] <= a2[ADD_LAT-1][k];
        end
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            vsh            <= '0;
            psh            <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_phase <= 1'b0;
            bus.a4_r       <= '0;
        end else begin
            vsh            <= {vsh[VLAT-2:0], state != IDLE};
            psh            <= {psh[VLAT-2:0], state == ODD};
            bus.dout_valid <= vsh[VLAT-1];
            if (vsh[VLAT-1]) begin
                bus.dout_phase <= psh[VLAT-1];
                bus.a4_r       <= a3[ADD_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_reconstruct_l5.sv
// Directed + random bench for reconstruct_l5 against a real-arithmetic fp32 reference model.
module tb_reconstruct_l5;
    localparam int unsigned LAT  = 17;
    localparam int unsigned NCYC = 4096;
    localparam logic [31:0] TL [8] = '{32'h3d03fc5f, 32'hbc4e80df, 32'hbdcb339e, 32'h3e9880d1,
                                       32'h3f4dc1d3, 32'h3efec7e0, 32'hbcf2c635, 32'hbd9b2b0e};
    localparam logic [31:0] TH [8] = '{32'hbd03fc5f, 32'hbc4e80df, 32'h3dcb339e, 32'h3e9880d1,
                                       32'hbf4dc1d3, 32'h3efec7e0, 32'h3cf2c635, 32'hbd9b2b0e};
    localparam logic [31:0] ONE = 32'h3f800000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reconstruct_l5_if bus();
    reconstruct_l5 dut (.clk_312_5(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          cyc = 0, n_asserts = 0, n_fail = 0;
    int          last_acc = -10, drop_at = -10, rst_at = -10, nacc = 0;
    bit          err_exp, dc_chk;
    bit [31:0]   exp_hold;
    bit          exp_v  [NCYC];
    bit          exp_ph [NCYC];
    bit [31:0]   exp_d  [NCYC];
    logic [31:0] ha_q[$], hd_q[$], const_q[$];

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) b = {f[31], 63'd0};
        else                  b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    // double -> fp32 with round-to-nearest-even (operands never reach the subnormal range)
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [23:0] m;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = int'(b[62:52]) - 896;
        m = {1'b0, b[51:29]};
        if (b[28] && ((|b[27:0]) || m[0])) m = m + 24'd1;
        if (m[23]) e = e + 1;
        if (e <= 0) return {b[63], 31'd0};
        return {b[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] mul_m(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] add_m(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] model_out(input int ph);
        logic [31:0] p [8];
        for (int j = 0; j < 4; j++) begin
            p[j]     = mul_m(ha_q[j], TL[2*j + ph]);
            p[j + 4] = mul_m(hd_q[j], TH[2*j + ph]);
        end
        return add_m(add_m(add_m(p[0], p[1]), add_m(p[2], p[3])),
                     add_m(add_m(p[4], p[5]), add_m(p[6], p[7])));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        int diff;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_at == cyc - 1) begin
            exp_hold = '0;
            err_exp  = 1'b0;
            chk("rst_phase", 32'(bus.dout_phase), 32'd0);
        end
        if (drop_at == cyc - 1) err_exp = 1'b1;
        if (exp_v[cyc]) exp_hold = exp_d[cyc];
        chk("dout_valid", 32'(bus.dout_valid), 32'(exp_v[cyc]));
        if (exp_v[cyc]) chk("dout_phase", 32'(bus.dout_phase), 32'(exp_ph[cyc]));
        chk("a4_r", bus.a4_r, exp_hold);
        chk("err_overrun", 32'(bus.err_overrun), 32'(err_exp));
        if (bus.dout_valid === 1'b1 && const_q.size() > 0)
            chk("impulse_tap", bus.a4_r, const_q.pop_front());
        if (dc_chk && bus.dout_valid === 1'b1) begin
            diff = int'(bus.a4_r) - int'(32'h3f3504f3);
            n_asserts++;
            assert (diff <= 2 && diff >= -2) else begin
                n_fail++;
                $error("FAIL dc_ulp at cycle %0d: observed %h expected 3f3504f3 +-2", cyc, bus.a4_r);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.din_valid = 1'b0;
            bus.a5_0      = $urandom;
            bus.d5_0      = $urandom;
            tick();
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        bus.din_valid = 1'b1;
        bus.a5_0      = a;
        bus.d5_0      = d;
        if (last_acc == cyc - 1) drop_at = cyc;
        else begin
            last_acc = cyc;
            ha_q.push_front(a);
            hd_q.push_front(d);
            if (ha_q.size() > 4) begin
                void'(ha_q.pop_back());
                void'(hd_q.pop_back());
            end
            if (nacc < 4) nacc++;
            if (nacc == 4) begin
                exp_v[cyc + LAT]      = 1'b1;
                exp_ph[cyc + LAT]     = 1'b0;
                exp_d[cyc + LAT]      = model_out(0);
                exp_v[cyc + LAT + 1]  = 1'b1;
                exp_ph[cyc + LAT + 1] = 1'b1;
                exp_d[cyc + LAT + 1]  = model_out(1);
            end
        end
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        for (int i = cyc + 1; i < int'(NCYC); i++) exp_v[i] = 1'b0;
        ha_q.delete();
        hd_q.delete();
        const_q.delete();
        nacc     = 0;
        last_acc = -10;
        rst_at   = cyc;
        tick();
        rst = 1'b0;
    endtask

    task automatic impulse(input logic [31:0] a, input logic [31:0] d, input bit det);
        do_reset();
        for (int i = 0; i < 3; i++) begin send('0, '0); idle(3); end
        for (int i = 0; i < 8; i++) const_q.push_back(det ? TH[i] : TL[i]);
        send(a, d);
        idle(3);
        for (int i = 0; i < 6; i++) begin send('0, '0); idle(3); end
        idle(20);
        chk(det ? "detail_impulse_drained" : "approx_impulse_drained", 32'(const_q.size()), 32'd0);
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.a5_0      = '0;
        bus.d5_0      = '0;
        do_reset();
        idle(2);

        impulse(ONE, '0, 1'b0);
        impulse('0, ONE, 1'b1);

        // DC at max input rate
        do_reset();
        dc_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin send(ONE, '0); idle(1); end
        idle(20);
        dc_chk = 1'b0;

        // overrun: second of two back-to-back pairs is dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin send(rnd_fp(), rnd_fp()); idle(2); end
        send(ONE, ONE);
        send(32'h40000000, 32'h40000000);
        idle(2);
        for (int i = 0; i < 4; i++) begin send(rnd_fp(), rnd_fp()); idle(2); end
        idle(20);

        // reset with several pairs in flight, then re-prime
        do_reset();
        for (int i = 0; i < 8; i++) begin send(rnd_fp(), rnd_fp()); idle(1); end
        idle(2);
        do_reset();
        for (int i = 0; i < 3; i++) begin send(rnd_fp(), rnd_fp()); idle(2); end
        idle(20);
        for (int i = 0; i < 3; i++) begin send(rnd_fp(), rnd_fp()); idle(2); end
        idle(22);

        // random data every 3 cycles
        do_reset();
        for (int i = 0; i < 24; i++) begin send(rnd_fp(), rnd_fp()); idle(2); end
        idle(22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
